// File: rtl/pong_pkg.sv
// Shared geometry, timing constants and state encoding for the pong game
// sequencer and the box-drawing instances.
package pong_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int PADDLE_W     = 5;
  localparam int PADDLE_H     = 50;
  localparam int P2_X         = 635;
  localparam int BALL_SZ      = 4;
  localparam int BALL_VX      = 2;
  localparam int BALL_VY      = 1;
  localparam int PADDLE_STEP  = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 7;

  localparam int PADDLE_Y_MAX  = SCREEN_H - PADDLE_H;
  localparam int PADDLE_Y_INIT = (SCREEN_H - PADDLE_H) / 2;
  localparam int BALL_X_INIT   = SCREEN_W / 2 - BALL_SZ / 2;
  localparam int BALL_Y_INIT   = SCREEN_H / 2 - BALL_SZ / 2;
  localparam int BALL_Y_MAX    = SCREEN_H - BALL_SZ;
  localparam int BALL_X_MAX    = P2_X - BALL_SZ;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  // Vertical overlap between the ball and a paddle, evaluated on 11 bits so
  // the sums near the bottom of the screen cannot wrap.
  function automatic logic paddle_overlap(input logic [9:0] ball_y, input logic [9:0] pad_y);
    return (({1'b0, ball_y} + 11'(BALL_SZ)) > {1'b0, pad_y}) &&
           ({1'b0, ball_y} < ({1'b0, pad_y} + 11'(PADDLE_H)));
  endfunction

endpackage

// File: rtl/pong_game_ctrl_paddle.sv
// Saturating paddle position register, stepped once per frame while enabled.
module pong_paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       enable_i,
  input  logic       init_i,
  input  logic       up_i,
  input  logic       dn_i,
  output logic [9:0] y_o
);

  localparam logic [9:0] STEP  = 10'(PADDLE_STEP);
  localparam logic [9:0] Y_MAX = 10'(PADDLE_Y_MAX);
  localparam logic [9:0] Y_INI = 10'(PADDLE_Y_INIT);

  logic [9:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (tick_i) begin
      if (init_i) begin
        y_d = Y_INI;
      end else if (enable_i && up_i && !dn_i) begin
        y_d = (y_q < STEP) ? 10'd0 : y_q - STEP;
      end else if (enable_i && dn_i && !up_i) begin
        y_d = (y_q > Y_MAX - STEP) ? Y_MAX : y_q + STEP;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) y_q <= Y_INI;
    else         y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/score state machine, ball physics and
// paddle control, advanced once per video frame.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       pixel_clk_i,
  input  logic       reset_n_i,
  input  logic       frame_tick_i,
  input  logic       start_i,
  input  logic       p1_up_i,
  input  logic       p1_dn_i,
  input  logic       p2_up_i,
  input  logic       p2_dn_i,
  output logic [9:0] p1_y_o,
  output logic [9:0] p2_y_o,
  output logic [9:0] ball_x_o,
  output logic [9:0] ball_y_o,
  output logic [3:0] score1_o,
  output logic [3:0] score2_o,
  output logic [2:0] state_o,
  output logic [1:0] winner_o
);

  localparam logic signed [10:0] VX     = 11'(BALL_VX);
  localparam logic signed [10:0] VY     = 11'(BALL_VY);
  localparam logic signed [10:0] X_MIN  = 11'(PADDLE_W);
  localparam logic signed [10:0] X_P2   = 11'(P2_X);
  localparam logic signed [10:0] SZ     = 11'(BALL_SZ);
  localparam logic signed [10:0] Y_MAXS = 11'(BALL_Y_MAX);

  game_state_t state_q, state_d;
  logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic        vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [3:0]  score1_q, score1_d, score2_q, score2_d;
  logic [1:0]  winner_q, winner_d;
  logic [5:0]  serve_cnt_q, serve_cnt_d;
  logic        scorer_p2_q, scorer_p2_d;
  logic        start_q;

  logic        start_rise, paddle_en, paddle_init;
  logic [9:0]  p1_y, p2_y;
  logic signed [10:0] nx, ny;
  logic        x_lo, x_hi, y_lo, y_hi, hit1, hit2, miss, won;
  logic [3:0]  score_inc;

  assign start_rise  = start_i & ~start_q;
  assign paddle_en   = (state_q == SERVE) || (state_q == PLAY);
  assign paddle_init = (state_q == GAME_OVER) && start_rise;

  pong_paddle_ctrl u_p1 (
    .clk_i(pixel_clk_i), .rst_ni(reset_n_i), .tick_i(frame_tick_i),
    .enable_i(paddle_en), .init_i(paddle_init),
    .up_i(p1_up_i), .dn_i(p1_dn_i), .y_o(p1_y)
  );

  pong_paddle_ctrl u_p2 (
    .clk_i(pixel_clk_i), .rst_ni(reset_n_i), .tick_i(frame_tick_i),
    .enable_i(paddle_en), .init_i(paddle_init),
    .up_i(p2_up_i), .dn_i(p2_dn_i), .y_o(p2_y)
  );

  // Candidate ball step and the wall/paddle events it would trigger.
  always_comb begin
    nx        = $signed({1'b0, ball_x_q}) + (vx_neg_q ? -VX : VX);
    ny        = $signed({1'b0, ball_y_q}) + (vy_neg_q ? -VY : VY);
    x_lo      = nx < X_MIN;
    x_hi      = (nx + SZ) > X_P2;
    y_lo      = ny <= 11'sd0;
    y_hi      = ny >= Y_MAXS;
    hit1      = paddle_overlap(ball_y_q, p1_y);
    hit2      = paddle_overlap(ball_y_q, p2_y);
    miss      = (x_lo && !hit1) || (!x_lo && x_hi && !hit2);
    score_inc = (scorer_p2_q ? score2_q : score1_q) + 4'd1;
    won       = score_inc == 4'(WIN_SCORE);
  end

  always_comb begin
    state_d = state_q;
    if (frame_tick_i) begin
      case (state_q)
        IDLE:      if (start_rise) state_d = SERVE;
        SERVE:     if (serve_cnt_q == 6'd1) state_d = PLAY;
        PLAY:      if (miss) state_d = POINT;
        POINT:     state_d = won ? GAME_OVER : SERVE;
        GAME_OVER: if (start_rise) state_d = SERVE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    vx_neg_d    = vx_neg_q;
    vy_neg_d    = vy_neg_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    serve_cnt_d = serve_cnt_q;
    scorer_p2_d = scorer_p2_q;
    if (frame_tick_i) begin
      case (state_q)
        IDLE, GAME_OVER: begin
          if (start_rise) begin
            ball_x_d    = 10'(BALL_X_INIT);
            ball_y_d    = 10'(BALL_Y_INIT);
            vx_neg_d    = 1'b0;
            vy_neg_d    = 1'b0;
            score1_d    = 4'd0;
            score2_d    = 4'd0;
            winner_d    = 2'd0;
            serve_cnt_d = 6'(SERVE_FRAMES);
          end
        end
        SERVE: serve_cnt_d = serve_cnt_q - 6'd1;
        PLAY: begin
          if (y_lo) begin
            ball_y_d = 10'd0;
            vy_neg_d = 1'b0;
          end else if (y_hi) begin
            ball_y_d = 10'(BALL_Y_MAX);
            vy_neg_d = 1'b1;
          end else begin
            ball_y_d = ny[9:0];
          end
          if (x_lo) begin
            if (hit1) begin
              ball_x_d = 10'(PADDLE_W);
              vx_neg_d = 1'b0;
            end else begin
              scorer_p2_d = 1'b1;
            end
          end else if (x_hi) begin
            if (hit2) begin
              ball_x_d = 10'(BALL_X_MAX);
              vx_neg_d = 1'b1;
            end else begin
              scorer_p2_d = 1'b0;
            end
          end else begin
            ball_x_d = nx[9:0];
          end
        end
        POINT: begin
          if (scorer_p2_q) score2_d = score_inc;
          else             score1_d = score_inc;
          if (won) begin
            winner_d = scorer_p2_q ? 2'd2 : 2'd1;
          end else begin
            // Next serve heads toward the player who just conceded.
            ball_x_d    = 10'(BALL_X_INIT);
            ball_y_d    = 10'(BALL_Y_INIT);
            vx_neg_d    = scorer_p2_q;
            vy_neg_d    = 1'b0;
            serve_cnt_d = 6'(SERVE_FRAMES);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      ball_x_q    <= 10'(BALL_X_INIT);
      ball_y_q    <= 10'(BALL_Y_INIT);
      vx_neg_q    <= 1'b0;
      vy_neg_q    <= 1'b0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      winner_q    <= 2'd0;
      serve_cnt_q <= 6'd0;
      scorer_p2_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      vx_neg_q    <= vx_neg_d;
      vy_neg_q    <= vy_neg_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      serve_cnt_q <= serve_cnt_d;
      scorer_p2_q <= scorer_p2_d;
      start_q     <= start_i;
    end
  end

  always_comb begin
    p1_y_o   = p1_y;
    p2_y_o   = p2_y;
    ball_x_o = ball_x_q;
    ball_y_o = ball_y_q;
    score1_o = score1_q;
    score2_o = score2_q;
    state_o  = state_q;
    winner_o = winner_q;
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a frame-level game model checked
// every cycle, plus directed literal checks of serve timing and saturation.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, frame_tick, start, p1_up, p1_dn, p2_up, p2_dn;
  logic [9:0] p1_y, p2_y, ball_x, ball_y;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic [1:0] winner;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .pixel_clk_i(clk), .reset_n_i(reset_n), .frame_tick_i(frame_tick),
    .start_i(start), .p1_up_i(p1_up), .p1_dn_i(p1_dn),
    .p2_up_i(p2_up), .p2_dn_i(p2_dn),
    .p1_y_o(p1_y), .p2_y_o(p2_y), .ball_x_o(ball_x), .ball_y_o(ball_y),
    .score1_o(score1), .score2_o(score2), .state_o(state), .winner_o(winner)
  );

  // Game model: state codes 0 idle, 1 serve, 2 play, 3 point, 4 game over.
  int m_state, m_p1, m_p2, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_win, m_cnt, m_scorer;
  bit m_start_prev;
  int errors = 0;
  int checks = 0;
  int points = 0;
  int games  = 0;
  bit cmp_en = 1'b0;

  task automatic model_reset();
    m_state = 0; m_p1 = 215; m_p2 = 215; m_bx = 318; m_by = 238;
    m_vx = 2; m_vy = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0;
    m_scorer = 0; m_start_prev = 1'b0;
  endtask

  function automatic int pad_move(input int y, input logic up, input logic dn);
    if (up && !dn) return (y - 3 < 0) ? 0 : y - 3;
    if (dn && !up) return (y + 3 > 430) ? 430 : y + 3;
    return y;
  endfunction

  task automatic serve_centre(input int vx);
    m_state = 1; m_bx = 318; m_by = 238; m_vx = vx; m_vy = 1; m_cnt = 60;
  endtask

  task automatic model_step();
    bit rise, ov1, ov2;
    int nx, ny;
    if (!reset_n) begin
      model_reset();
      return;
    end
    rise = start && !m_start_prev;
    m_start_prev = start;
    if (!frame_tick) return;
    case (m_state)
      0: if (rise) serve_centre(2);
      1: begin
        m_p1 = pad_move(m_p1, p1_up, p1_dn);
        m_p2 = pad_move(m_p2, p2_up, p2_dn);
        if (m_cnt == 1) m_state = 2;
        m_cnt = m_cnt - 1;
      end
      2: begin
        ov1 = (m_by + 4 > m_p1) && (m_by < m_p1 + 50);
        ov2 = (m_by + 4 > m_p2) && (m_by < m_p2 + 50);
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        if (ny <= 0) begin m_by = 0; m_vy = 1; end
        else if (ny >= 476) begin m_by = 476; m_vy = -1; end
        else m_by = ny;
        if (nx < 5) begin
          if (ov1) begin m_bx = 5; m_vx = 2; end
          else begin m_state = 3; m_scorer = 2; end
        end else if (nx + 4 > 635) begin
          if (ov2) begin m_bx = 631; m_vx = -2; end
          else begin m_state = 3; m_scorer = 1; end
        end else begin
          m_bx = nx;
        end
        m_p1 = pad_move(m_p1, p1_up, p1_dn);
        m_p2 = pad_move(m_p2, p2_up, p2_dn);
      end
      3: begin
        if (m_scorer == 1) m_s1++; else m_s2++;
        points++;
        $display("point %0d: scorer P%0d score1=%0d score2=%0d", points, m_scorer, m_s1, m_s2);
        if (m_s1 == 7 || m_s2 == 7) begin
          m_state = 4; m_win = m_scorer; games++;
          $display("game %0d over: winner P%0d", games, m_win);
        end else begin
          serve_centre((m_scorer == 2) ? -2 : 2);
        end
      end
      4: if (rise) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_p1 = 215; m_p2 = 215;
        serve_centre(2);
      end
      default: ;
    endcase
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (p1_y !== 10'(m_p1) || p2_y !== 10'(m_p2) || ball_x !== 10'(m_bx) ||
          ball_y !== 10'(m_by) || score1 !== 4'(m_s1) || score2 !== 4'(m_s2) ||
          state !== 3'(m_state) || winner !== 2'(m_win)) begin
        errors++;
        if (errors < 20)
          $display("FAIL model_cmp t=%0t dut p1=%0d p2=%0d bx=%0d by=%0d s1=%0d s2=%0d st=%0d w=%0d exp p1=%0d p2=%0d bx=%0d by=%0d s1=%0d s2=%0d st=%0d w=%0d",
                   $time, p1_y, p2_y, ball_x, ball_y, score1, score2, state, winner,
                   m_p1, m_p2, m_bx, m_by, m_s1, m_s2, m_state, m_win);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock: model follows the edge; returns at the next falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
      cycle();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_p1"}, p1_y, 215);
    check({tag, "_p2"}, p2_y, 215);
    check({tag, "_bx"}, ball_x, 318);
    check({tag, "_by"}, ball_y, 238);
    check({tag, "_s1"}, score1, 0);
    check({tag, "_s2"}, score2, 0);
    check({tag, "_state"}, state, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    cmp_en = 1'b1;

    ticks(5);
    check_reset_vals("idle_no_start");

    // Start rises on a tick and is then held high through the whole serve.
    start = 1'b1; frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    check("start_serve_state", state, 1);
    p1_up = 1'b1; p2_dn = 1'b1;
    ticks(59);
    check("serve59_state", state, 1);
    check("serve59_bx", ball_x, 318);
    ticks(1);
    check("serve60_state", state, 2);
    check("serve60_bx", ball_x, 318);
    check("serve60_by", ball_y, 238);
    check("serve60_p1", p1_y, 35);
    check("serve60_p2", p2_y, 395);
    ticks(1);
    check("play1_bx", ball_x, 320);
    check("play1_by", ball_y, 239);
    ticks(10);
    check("sat71_p1", p1_y, 2);
    check("sat71_p2", p2_y, 428);
    ticks(1);
    check("sat72_p1", p1_y, 0);
    check("sat72_p2", p2_y, 430);
    ticks(8);
    check("sat80_p1", p1_y, 0);
    check("sat80_p2", p2_y, 430);
    check("sat80_state", state, 2);
    check("sat80_bx", ball_x, 358);
    p1_dn = 1'b1; p2_up = 1'b1;
    ticks(3);
    check("both_p1", p1_y, 0);
    check("both_p2", p2_y, 430);
    start = 1'b0;

    // Randomised play with occasional restarts and one async reset mid-game.
    for (int cyc = 0; cyc < 60000; cyc++) begin
      frame_tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) begin
        p1_up = $urandom_range(0, 2) == 0;
        p1_dn = $urandom_range(0, 2) == 0;
        p2_up = $urandom_range(0, 2) == 0;
        p2_dn = $urandom_range(0, 2) == 0;
      end
      if ($urandom_range(0, 299) == 0) start = ~start;
      if (cyc == 20000) begin
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_reset");
        model_reset();
        @(negedge clk);
        cycle();
        reset_n = 1'b1;
      end
      cycle();
    end

    $display("info: points=%0d games=%0d", points, games);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
